// File: rtl/loop_sched_pkg.sv
// Shared types and defaults for the loop iteration scheduler.
//   loop_state_e  : engine FSM states (idle, running indices, finishing)
//   IDX_W_DEFAULT : default index/limit width, matches loop_if.index
package loop_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } loop_state_e;

    localparam int IDX_W_DEFAULT = 4;

endpackage : loop_sched_pkg

// File: rtl/loop_iter_scheduler_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// The search starts at ptr_i and wraps, so the requester at the pointer has
// the highest priority and the one just before it the lowest.
//   req_i     : request vector
//   ptr_i     : index of the highest-priority requester
//   gnt_o     : one-hot grant (all zero when nothing is requested)
//   gnt_idx_o : binary index of the granted requester
//   any_o     : at least one request present
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic [PTR_W-1:0] cand_s;
    logic             found_s;

    // Walk the requesters starting at the pointer; first set request wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = PTR_W'((int'(ptr_i) + i) % NREQ);
            if (!found_s && req_i[cand_s]) begin
                found_s        = 1'b1;
                gnt_o[cand_s]  = 1'b1;
                gnt_idx_o      = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        any_o = found_s;
    end

endmodule : rr_arbiter

// File: rtl/loop_iter_scheduler.sv
// Loop iteration scheduler: shares one index-sweep engine between NREQ
// requesters. A granted job of limit L presents lif_index 0..L-1 on L
// consecutive cycles, then lif_done pulses for one cycle with done_id naming
// the job owner. All outputs are registered.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester level request, held until ack
//   req_limit  : per-requester iteration limit, captured on grant
//   ack        : one-hot 1-cycle pulse, job accepted
//   busy       : engine stepping indices
//   owner      : one-hot owner of the current job, 0 when idle
//   lif_index  : loop_if.index
//   lif_done   : loop_if.done, 1-cycle pulse at job end
//   done_id    : one-hot owner of the finished job while lif_done=1
//
// Cycle view for a job acked in cycle T with limit L:
//   T..T+L-1 : RUN, index 0..L-1, busy=1
//   T+L      : FIN, index holds, owner still valid, busy=0
//   T+L+1    : IDLE, lif_done/done_id pulse, index still holds
// With L=0 the engine goes straight to FIN in cycle T, so done follows ack by
// one cycle with index 0.
module loop_iter_scheduler
    import loop_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = IDX_W_DEFAULT,
    parameter int GAP   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*IDX_W-1:0]   req_limit,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [NREQ-1:0]         owner,
    output logic [IDX_W-1:0]        lif_index,
    output logic                    lif_done,
    output logic [NREQ-1:0]         done_id
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    loop_state_e      state_q,     state_d;
    logic [IDX_W-1:0] limit_q,     limit_d;
    logic [IDX_W-1:0] index_q,     index_d;
    logic [PTR_W-1:0] ptr_q,       ptr_d;
    logic [NREQ-1:0]  owner_q,     owner_d;
    logic [PTR_W-1:0] owner_idx_q, owner_idx_d;
    logic [NREQ-1:0]  ack_q,       ack_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [NREQ-1:0]  done_id_q,   done_id_d;

    logic [IDX_W-1:0] lim_arr_s [NREQ];
    logic [IDX_W-1:0] sel_limit_s;
    logic [NREQ-1:0]  gnt_s;
    logic [PTR_W-1:0] gnt_idx_s;
    logic             any_s;
    logic [PTR_W-1:0] ptr_fin_s;
    logic [PTR_W-1:0] arb_ptr_s;
    logic             take_s;

    // Split the flat limit bus into per-requester slices.
    for (genvar g = 0; g < NREQ; g++) begin : g_lim
        assign lim_arr_s[g] = req_limit[g*IDX_W +: IDX_W];
    end

    assign sel_limit_s = lim_arr_s[gnt_idx_s];

    // Pointer value after the current owner, wrapping at NREQ.
    assign ptr_fin_s = (owner_idx_q == PTR_W'(NREQ - 1)) ? '0
                                                           : owner_idx_q + PTR_W'(1);

    // In FIN the pointer register has not moved yet, so a same-cycle grant
    // (GAP=0) must already use the advanced pointer to stay fair.
    assign arb_ptr_s = (state_q == S_FIN) ? ptr_fin_s : ptr_q;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i     (req),
        .ptr_i     (arb_ptr_s),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .any_o     (any_s)
    );

    // Next-state and next-output logic of the engine FSM.
    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        index_d     = index_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_idx_d = owner_idx_q;
        ack_d       = '0;
        done_d      = 1'b0;
        done_id_d   = '0;
        take_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                index_d = '0;
                owner_d = '0;
                take_s  = any_s;
            end
            S_RUN: begin
                // Captured limit only; a live req_limit change has no effect.
                if (index_q == limit_q - IDX_W'(1)) begin
                    state_d = S_FIN;
                end else begin
                    index_d = index_q + IDX_W'(1);
                end
            end
            S_FIN: begin
                // Index holds so lif_done is seen alongside the last index.
                done_d    = 1'b1;
                done_id_d = owner_q;
                ptr_d     = ptr_fin_s;
                owner_d   = '0;
                state_d   = S_IDLE;
                if ((GAP == 0) && any_s) begin
                    take_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                index_d = '0;
                owner_d = '0;
            end
        endcase

        if (take_s) begin
            ack_d       = gnt_s;
            owner_d     = gnt_s;
            owner_idx_d = gnt_idx_s;
            limit_d     = sel_limit_s;
            index_d     = '0;
            if (sel_limit_s == '0) begin
                state_d = S_FIN;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            ack_d = '0;
        end

        busy_d = (state_d == S_RUN);
    end

    // State and registered outputs; reset clears everything including the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            limit_q     <= '0;
            index_q     <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_idx_q <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            index_q     <= index_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_idx_q <= owner_idx_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign lif_index = index_q;
    assign lif_done  = done_q;
    assign done_id   = done_id_q;

endmodule : loop_iter_scheduler

// File: tb/tb_loop_iter_scheduler.sv
// Self-checking bench for loop_iter_scheduler (NREQ=2, IDX_W=4, GAP=1).
// A job-level model predicts every output from the ack cycle, limit and winner
// of the current job; directed scenarios add literal expectations.
module tb_loop_iter_scheduler;

    localparam int NREQ  = 2;
    localparam int IDX_W = 4;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [IDX_W-1:0]      lim [NREQ];
    logic [NREQ*IDX_W-1:0] req_limit;
    logic [NREQ-1:0]       ack, owner, done_id;
    logic                  busy, lif_done;
    logic [IDX_W-1:0]      lif_index;

    int n_checks = 0;
    int n_fail   = 0;

    assign req_limit = {lim[1], lim[0]};

    always #5 clk = ~clk;

    loop_iter_scheduler #(.NREQ(NREQ), .IDX_W(IDX_W), .GAP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_limit (req_limit),
        .ack       (ack),
        .busy      (busy),
        .owner     (owner),
        .lif_index (lif_index),
        .lif_done  (lif_done),
        .done_id   (done_id)
    );

    // ---------------- model state ----------------
    int cyc     = 0;
    bit has_job = 1'b0;
    int m_ack_at, m_L, m_w, m_ptr, m_c;
    bit m_found;

    // ---------------- logs for literal checks ----------------
    int ack_log[$];
    int done_log[$];
    int idx_log[$];
    int done_idx;
    int last_ack_cyc;
    int last_lat;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Job-level model: grant decided from req seen at the edge when the engine is free.
    initial begin
        m_ptr = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                has_job = 1'b0;
                m_ptr   = 0;
            end else if ((!has_job || cyc >= m_ack_at + m_L + 1) && req != '0) begin
                m_found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    m_c = (m_ptr + k) % NREQ;
                    if (!m_found && req[m_c]) begin
                        m_found = 1'b1;
                        m_w     = m_c;
                    end
                end
                m_L      = int'(lim[m_w]);
                m_ack_at = cyc + 1;
                m_ptr    = (m_w + 1) % NREQ;
                has_job  = 1'b1;
            end
            cyc = cyc + 1;
        end
    end

    // Compare every cycle against the model, and log events.
    initial begin
        int e_ack, e_busy, e_owner, e_idx, e_done, e_did, oh, t;
        forever begin
            @(negedge clk);
            e_ack = 0; e_busy = 0; e_owner = 0; e_idx = 0; e_done = 0; e_did = 0;
            if (rst_n && has_job) begin
                t  = cyc;
                oh = 1 << m_w;
                if (t == m_ack_at) e_ack = oh;
                if (t >= m_ack_at && t < m_ack_at + m_L) begin
                    e_busy = 1;
                    e_idx  = t - m_ack_at;
                end
                if (t >= m_ack_at && t <= m_ack_at + m_L) e_owner = oh;
                if (t == m_ack_at + m_L || t == m_ack_at + m_L + 1)
                    e_idx = (m_L == 0) ? 0 : m_L - 1;
                if (t == m_ack_at + m_L + 1) begin
                    e_done = 1;
                    e_did  = oh;
                end
            end
            check("ack",       int'(ack),       e_ack);
            check("busy",      int'(busy),      e_busy);
            check("owner",     int'(owner),     e_owner);
            check("lif_index", int'(lif_index), e_idx);
            check("lif_done",  int'(lif_done),  e_done);
            check("done_id",   int'(done_id),   e_did);

            if (ack != '0) begin
                ack_log.push_back(int'(ack));
                last_ack_cyc = cyc;
            end
            if (busy) idx_log.push_back(int'(lif_index));
            if (lif_done) begin
                done_log.push_back(int'(done_id));
                done_idx = int'(lif_index);
                last_lat = cyc - last_ack_cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ack_log.delete();
        done_log.delete();
        idx_log.delete();
        done_idx = -1;
        last_lat = -1;
    endtask

    task automatic wait_ack(input int maxc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            step();
            if (ack != '0) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ack: no ack within %0d cycles", maxc);
        end
    endtask

    task automatic wait_done(input int n_target, input int maxc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_log.size() >= n_target) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: %0d done pulses not seen within %0d cycles", n_target, maxc);
        end
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios.
    initial begin
        int n_ack;
        bit hit;
        lim[0] = '0;
        lim[1] = '0;
        clear_logs();

        // 1. Reset
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("rst_ack",   int'(ack),       0);
        check("rst_busy",  int'(busy),      0);
        check("rst_owner", int'(owner),     0);
        check("rst_index", int'(lif_index), 0);
        check("rst_done",  int'(lif_done),  0);
        check("rst_did",   int'(done_id),   0);

        // 2. Single job, requester 0, limit 3
        clear_logs();
        lim[0] = 4'd3;
        req    = 2'b01;
        wait_ack(10);
        req = 2'b00;
        wait_done(1, 20);
        check("t2_idx_cnt", idx_log.size(), 3);
        if (idx_log.size() == 3) begin
            check("t2_idx0", idx_log[0], 0);
            check("t2_idx1", idx_log[1], 1);
            check("t2_idx2", idx_log[2], 2);
        end
        check("t2_ack",     (ack_log.size() == 1) ? ack_log[0] : -1, 1);
        check("t2_done_id", (done_log.size() == 1) ? done_log[0] : -1, 1);
        check("t2_latency", last_lat, 4);
        check("t2_busy_at_done", int'(busy), 0);
        repeat (2) step();

        // 4. Zero limit on requester 1 (pointer now at 1)
        clear_logs();
        lim[1] = 4'd0;
        req    = 2'b10;
        wait_ack(10);
        check("t4_ack", int'(ack), 2);
        req = 2'b00;
        wait_done(1, 10);
        check("t4_latency",  last_lat, 1);
        check("t4_done_idx", done_idx, 0);
        check("t4_done_id",  (done_log.size() == 1) ? done_log[0] : -1, 2);
        check("t4_run_cycles", idx_log.size(), 0);
        repeat (2) step();

        // 3. Contention, both requesters held (pointer back at 0)
        clear_logs();
        lim[0] = 4'd2;
        lim[1] = 4'd1;
        req    = 2'b11;
        n_ack  = 0;
        for (int i = 0; i < 60 && n_ack < 4; i++) begin
            step();
            if (ack != '0) n_ack++;
        end
        req = 2'b00;
        check("t3_ack_count", n_ack, 4);
        wait_done(4, 20);
        if (ack_log.size() == 4 && done_log.size() == 4) begin
            check("t3_gnt0", ack_log[0], 1);
            check("t3_gnt1", ack_log[1], 2);
            check("t3_gnt2", ack_log[2], 1);
            check("t3_gnt3", ack_log[3], 2);
            check("t3_did0", done_log[0], 1);
            check("t3_did1", done_log[1], 2);
            check("t3_did2", done_log[2], 1);
            check("t3_did3", done_log[3], 2);
        end else begin
            check("t3_log_sizes", ack_log.size() * 10 + done_log.size(), 44);
        end
        repeat (2) step();

        // 5. Maximum limit
        clear_logs();
        lim[0] = 4'd15;
        req    = 2'b01;
        wait_ack(10);
        req = 2'b00;
        wait_done(1, 40);
        check("t5_latency",  last_lat, 16);
        check("t5_idx_cnt",  idx_log.size(), 15);
        if (idx_log.size() == 15) begin
            check("t5_idx_first", idx_log[0], 0);
            check("t5_idx_last",  idx_log[14], 14);
        end
        check("t5_done_idx", done_idx, 14);
        repeat (2) step();

        // 6. Reset in the middle of a job
        clear_logs();
        lim[0] = 4'd10;
        req    = 2'b01;
        wait_ack(10);
        req = 2'b00;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (lif_index == 4'd4) hit = 1'b1;
            else step();
        end
        check("t6_reached_idx4", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  int'(busy),      0);
        check("t6_rst_owner", int'(owner),     0);
        check("t6_rst_index", int'(lif_index), 0);
        check("t6_rst_done",  int'(lif_done),  0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (15) step();
        check("t6_no_done", done_log.size(), 0);
        lim[0] = 4'd1;
        lim[1] = 4'd1;
        req    = 2'b11;
        wait_ack(10);
        check("t6_first_gnt", int'(ack), 1);
        req = 2'b00;
        wait_done(1, 10);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_loop_iter_scheduler
